rtc_cnt_ctrl: RTL and testbench
===============================

// Module: rtc_cnt_ctrl
// PURPOSE
//  Control stage directly upstream of the RTC counter, in the rtc_clk (always-on) domain.
//  Synchronises the APB-side enable and counter-load request into rtc_clk.
//  Generates the prescaled count-enable tick (cnt_en).
//  Produces the one-cycle load pulse (pdu_aou_wen_clr_sync) with captured load data (pdu_aou_clr_reg).
// PARAMETERS
//  PRE_W        16  prescaler width; divide ratio = prescale+1 (1..2^PRE_W)
//  SYNC_STAGES  2   synchroniser depth for enable and request toggle (>=2)
// PORTS
//  rtc_clk               in   1      RTC clock; all flops on posedge
//  rtc_rst               in   1      reset, asynchronous, active-high
//  pdu_aou_en            in   1      counter enable level, APB domain, quasi-static
//  pdu_aou_prescale      in   PRE_W  prescale value, quasi-static, used directly
//  pdu_aou_wen_clr_tgl   in   1      load request toggle, APB domain
//  pdu_aou_clr_data      in   32     load value; source holds it stable from toggle until ack
//  aou_pdu_clr_ack_tgl   out  1      load acknowledge toggle back to APB domain
//  aou_pdu_en_sync       out  1      synchronised enable status
//  cnt_en                out  1      count tick, one rtc_clk cycle wide
//  pdu_aou_wen_clr_sync  out  1      load strobe, one cycle wide
//  pdu_aou_clr_reg       out  32     load value, valid while strobe is high, held afterwards
// BEHAVIOUR
//  Reset (rtc_rst=1, async): all outputs 0; synchronisers, pre_cnt and req_last cleared; FSM=IDLE.
//  Enable sync: SYNC_STAGES flops; en_s = last stage = aou_pdu_en_sync.
//  Request sync:
//   - SYNC_STAGES flops plus req_last flop.
//   - req_det = sync_out ^ req_last.
//   - On the req_det edge: pdu_aou_clr_reg <= pdu_aou_clr_data, pdu_aou_wen_clr_sync <= 1, aou_pdu_clr_ack_tgl <= ~ack.
//   - Strobe is high for exactly one cycle.
//   - Latency: strobe is high after SYNC_STAGES+1 rtc_clk edges following the toggle.
//  Load requests are serviced in both IDLE and RUN.
//  Source protocol: at most one outstanding toggle; it waits for the ack toggle before issuing the next.
//  Double toggles within the sync window are not detected (source violation).
//  Prescaler FSM:
//   - IDLE: pre_cnt=0, cnt_en=0. IDLE->RUN when en_s=1.
//   - RUN: tick = (pre_cnt >= prescale). On tick: pre_cnt <= 0 and cnt_en <= 1. Otherwise pre_cnt++ and cnt_en <= 0.
//   - RUN->IDLE when en_s=0. pre_cnt and cnt_en clear on that same edge.
//  Comparison uses >=. If prescale is lowered below the current pre_cnt, a tick fires on the next edge
//   instead of wrapping through 2^PRE_W.
//  prescale=0: cnt_en stays high every cycle while in RUN.
//  Simultaneous load and tick (req_det in RUN): load wins.
//   - pre_cnt <= 0, cnt_en <= 0 that edge.
//   - First tick after the load comes prescale+1 cycles later.
//  Re-enable: the first tick comes prescale+1 cycles after entering RUN.
//  Reset mid-operation aborts any in-flight request (ack returns to 0; the APB side resets in step).
// TESTING
//  1 RUN with prescale=3, pre_cnt=2, assert rtc_rst between edges -> all outputs 0 immediately, IDLE after release.
//  2 en 0->1, prescale=3 -> aou_pdu_en_sync high after 2 edges; cnt_en pulses 1 cycle wide, every 4 cycles.
//  3 prescale=0, en=1 -> cnt_en held high every cycle in RUN; en 1->0 -> cnt_en low on the edge after en_s falls.
//  4 toggle with data 0xDEADBEEF, prescale=9 ->
//     strobe for 1 cycle at edge 3 after the toggle; clr_reg=0xDEADBEEF; ack toggles on the same edge;
//     next cnt_en 10 cycles later.
//  5 prescale 100->5 while pre_cnt=50 -> cnt_en on next edge, then every 6 cycles.
//  6 toggle arriving on the cycle a tick is due -> strobe=1, cnt_en=0 that cycle, pre_cnt=0.

Source files
------------

// File: rtl/rtc_cnt_ctrl_if.sv
// Signal bundle between the APB-side control registers and the rtc_clk-domain
// counter control stage.
interface rtc_cnt_ctrl_if #(
    parameter int PRE_W = 16
);
    logic             pdu_aou_en;
    logic [PRE_W-1:0] pdu_aou_prescale;
    logic             pdu_aou_wen_clr_tgl;
    logic [31:0]      pdu_aou_clr_data;
    logic             aou_pdu_clr_ack_tgl;
    logic             aou_pdu_en_sync;
    logic             cnt_en;
    logic             pdu_aou_wen_clr_sync;
    logic [31:0]      pdu_aou_clr_reg;

    modport master (
        output pdu_aou_en,
        output pdu_aou_prescale,
        output pdu_aou_wen_clr_tgl,
        output pdu_aou_clr_data,
        input  aou_pdu_clr_ack_tgl,
        input  aou_pdu_en_sync,
        input  cnt_en,
        input  pdu_aou_wen_clr_sync,
        input  pdu_aou_clr_reg
    );

    modport slave (
        input  pdu_aou_en,
        input  pdu_aou_prescale,
        input  pdu_aou_wen_clr_tgl,
        input  pdu_aou_clr_data,
        output aou_pdu_clr_ack_tgl,
        output aou_pdu_en_sync,
        output cnt_en,
        output pdu_aou_wen_clr_sync,
        output pdu_aou_clr_reg
    );
endinterface

// File: rtl/rtc_cnt_ctrl.sv
// RTC counter control in the rtc_clk domain: synchronises enable and load-request
// toggle, generates the prescaled count tick and the one-cycle load strobe.
//
// state | meaning
// IDLE  | prescaler held at 0, no count ticks
// RUN   | prescaler counting, cnt_en pulses every prescale+1 cycles
module rtc_cnt_ctrl #(
    parameter int PRE_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic           rtc_clk,
    input logic           rtc_rst,
    rtc_cnt_ctrl_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] en_pipe;
    logic [SYNC_STAGES-1:0] req_pipe;
    logic                   en_s;
    logic                   req_last;
    logic                   req_det;
    logic [PRE_W-1:0]       pre_cnt;
    logic [PRE_W-1:0]       pre_cnt_next;
    logic                   cnt_en_q;
    logic                   cnt_en_next;
    logic                   strobe;
    logic                   ack;
    logic [31:0]            clr_reg;

    assign en_s    = en_pipe[SYNC_STAGES-1];
    assign req_det = req_pipe[SYNC_STAGES-1] ^ req_last;

    always_ff @(posedge rtc_clk or posedge rtc_rst) begin
        if (rtc_rst) begin
            en_pipe  <= '0;
            req_pipe <= '0;
            req_last <= 1'b0;
        end else begin
            en_pipe  <= {en_pipe[SYNC_STAGES-2:0], bus.pdu_aou_en};
            req_pipe <= {req_pipe[SYNC_STAGES-2:0], bus.pdu_aou_wen_clr_tgl};
            req_last <= req_pipe[SYNC_STAGES-1];
        end
    end

    // Load data is held stable by the source until ack, so it is sampled directly.
    always_ff @(posedge rtc_clk or posedge rtc_rst) begin
        if (rtc_rst) begin
            strobe  <= 1'b0;
            ack     <= 1'b0;
            clr_reg <= '0;
        end else begin
            strobe <= req_det;
            if (req_det) begin
                clr_reg <= bus.pdu_aou_clr_data;
                ack     <= ~ack;
            end
        end
    end

    always_ff @(posedge rtc_clk or posedge rtc_rst) begin
        if (rtc_rst) begin
            state    <= IDLE;
            pre_cnt  <= '0;
            cnt_en_q <= 1'b0;
        end else begin
            state    <= state_next;
            pre_cnt  <= pre_cnt_next;
            cnt_en_q <= cnt_en_next;
        end
    end

    // >= rather than == so a prescale lowered below pre_cnt ticks at once.
    always_comb begin
        state_next   = state;
        pre_cnt_next = '0;
        cnt_en_next  = 1'b0;
        case (state)
            IDLE: begin
                if (en_s) state_next = RUN;
            end
            RUN: begin
                if (!en_s) begin
                    state_next = IDLE;
                end else if (!req_det) begin
                    if (pre_cnt >= bus.pdu_aou_prescale) cnt_en_next = 1'b1;
                    else pre_cnt_next = pre_cnt + PRE_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.aou_pdu_en_sync      = en_s;
    assign bus.cnt_en               = cnt_en_q;
    assign bus.pdu_aou_wen_clr_sync = strobe;
    assign bus.aou_pdu_clr_ack_tgl  = ack;
    assign bus.pdu_aou_clr_reg      = clr_reg;
endmodule

// File: tb/tb_rtc_cnt_ctrl.sv
// Bench for rtc_cnt_ctrl: directed scenarios plus randomized traffic, checked
// against a cycle-level behavioural model of the enable, prescale and load rules.
module tb_rtc_cnt_ctrl;
    localparam int PRE_W = 16;
    localparam int SYNC  = 2;

    logic rtc_clk = 1'b0;
    logic rtc_rst = 1'b1;

    rtc_cnt_ctrl_if #(.PRE_W(PRE_W)) bus ();

    rtc_cnt_ctrl #(.PRE_W(PRE_W), .SYNC_STAGES(SYNC)) dut (
        .rtc_clk(rtc_clk),
        .rtc_rst(rtc_rst),
        .bus    (bus)
    );

    always #5 rtc_clk = ~rtc_clk;

    int vectors = 0;
    int errors  = 0;
    int edge_no = 0;

    // model state
    bit          en_hist[$];
    int          due_q[$];
    logic [31:0] data_q[$];
    bit          m_run;
    int          m_pre;
    bit          m_cnt_en;
    bit          m_strobe;
    bit          m_ack;
    bit          m_en_sync;
    logic [31:0] m_clr;

    task automatic model_reset();
        en_hist.delete();
        for (int i = 0; i < SYNC; i++) en_hist.push_back(1'b0);
        due_q.delete();
        data_q.delete();
        m_run = 0; m_pre = 0; m_cnt_en = 0; m_strobe = 0; m_ack = 0; m_en_sync = 0; m_clr = '0;
    endtask

    // Advance one rtc_clk edge; the model sees the inputs that were stable before the edge.
    task automatic step();
        bit          en_in;
        int          pre_in;
        bit          en_s_pre;
        bit          load;
        logic [31:0] ld;
        en_in  = bus.pdu_aou_en;
        pre_in = int'(bus.pdu_aou_prescale);
        @(posedge rtc_clk);
        edge_no++;
        #1;
        en_s_pre = en_hist[0];
        en_hist.push_back(en_in);
        void'(en_hist.pop_front());
        load = 0;
        ld   = '0;
        if (due_q.size() > 0 && due_q[0] == edge_no) begin
            load = 1;
            ld   = data_q.pop_front();
            void'(due_q.pop_front());
        end
        if (m_run && en_s_pre) begin
            if (load)                begin m_pre = 0; m_cnt_en = 0; end
            else if (m_pre >= pre_in) begin m_pre = 0; m_cnt_en = 1; end
            else                     begin m_pre = m_pre + 1; m_cnt_en = 0; end
        end else begin
            m_pre = 0; m_cnt_en = 0;
        end
        m_run     = en_s_pre;
        m_strobe  = load;
        if (load) begin m_clr = ld; m_ack = ~m_ack; end
        m_en_sync = en_hist[0];
    endtask

    task automatic do_toggle(input logic [31:0] data);
        bus.pdu_aou_clr_data    = data;
        bus.pdu_aou_wen_clr_tgl = ~bus.pdu_aou_wen_clr_tgl;
        due_q.push_back(edge_no + SYNC + 1);
        data_q.push_back(data);
    endtask

    task automatic test_reset();
        bus.pdu_aou_en = 0; bus.pdu_aou_prescale = '0;
        bus.pdu_aou_wen_clr_tgl = 0; bus.pdu_aou_clr_data = '0;
        rtc_rst = 1;
        model_reset();
        repeat (2) @(posedge rtc_clk);
        #1;
        vectors += 5;
        if (bus.aou_pdu_en_sync !== 1'b0) begin errors++; $display("FAIL reset en_sync: got %b want 0", bus.aou_pdu_en_sync); end
        if (bus.cnt_en !== 1'b0) begin errors++; $display("FAIL reset cnt_en: got %b want 0", bus.cnt_en); end
        if (bus.pdu_aou_wen_clr_sync !== 1'b0) begin errors++; $display("FAIL reset strobe: got %b want 0", bus.pdu_aou_wen_clr_sync); end
        if (bus.aou_pdu_clr_ack_tgl !== 1'b0) begin errors++; $display("FAIL reset ack: got %b want 0", bus.aou_pdu_clr_ack_tgl); end
        if (bus.pdu_aou_clr_reg !== 32'h0) begin errors++; $display("FAIL reset clr_reg: got %h want 0", bus.pdu_aou_clr_reg); end
        rtc_rst = 0;
    endtask

    task automatic test_enable();
        int last_tick = -1;
        bus.pdu_aou_prescale = 16'd3;
        bus.pdu_aou_en = 1;
        for (int i = 1; i <= 24; i++) begin
            step();
            vectors += 3;
            if (bus.aou_pdu_en_sync !== (i >= 2)) begin errors++; $display("FAIL enable en_sync step %0d: got %b want %b", i, bus.aou_pdu_en_sync, (i >= 2)); end
            if (bus.cnt_en !== m_cnt_en) begin errors++; $display("FAIL enable cnt_en step %0d: got %b want %b", i, bus.cnt_en, m_cnt_en); end
            if (bus.cnt_en !== (i >= 7 && (i - 7) % 4 == 0)) begin errors++; $display("FAIL enable tick_time step %0d: got %b want %b", i, bus.cnt_en, (i >= 7 && (i - 7) % 4 == 0)); end
            if (bus.cnt_en === 1'b1) begin
                if (last_tick >= 0) begin
                    vectors++;
                    if (i - last_tick != 4) begin errors++; $display("FAIL enable tick_spacing: got %0d want 4", i - last_tick); end
                end
                last_tick = i;
            end
        end
    endtask

    task automatic test_prescale_zero();
        bus.pdu_aou_prescale = '0;
        for (int i = 1; i <= 10; i++) begin
            step();
            vectors += 2;
            if (bus.cnt_en !== m_cnt_en) begin errors++; $display("FAIL pz_run cnt_en step %0d: got %b want %b", i, bus.cnt_en, m_cnt_en); end
            if (i >= 2 && bus.cnt_en !== 1'b1) begin errors++; $display("FAIL pz_held cnt_en step %0d: got %b want 1", i, bus.cnt_en); end
        end
        bus.pdu_aou_en = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            vectors += 3;
            if (bus.cnt_en !== (i <= 2)) begin errors++; $display("FAIL pz_off cnt_en step %0d: got %b want %b", i, bus.cnt_en, (i <= 2)); end
            if (bus.cnt_en !== m_cnt_en) begin errors++; $display("FAIL pz_off_model cnt_en step %0d: got %b want %b", i, bus.cnt_en, m_cnt_en); end
            if (bus.aou_pdu_en_sync !== m_en_sync) begin errors++; $display("FAIL pz_off en_sync step %0d: got %b want %b", i, bus.aou_pdu_en_sync, m_en_sync); end
        end
    endtask

    task automatic test_load();
        bus.pdu_aou_prescale = 16'd9;
        bus.pdu_aou_en = 1;
        repeat (4) step();
        do_toggle(32'hDEADBEEF);
        for (int i = 1; i <= 15; i++) begin
            step();
            vectors += 4;
            if (bus.pdu_aou_wen_clr_sync !== (i == 3)) begin errors++; $display("FAIL load strobe step %0d: got %b want %b", i, bus.pdu_aou_wen_clr_sync, (i == 3)); end
            if (bus.aou_pdu_clr_ack_tgl !== m_ack) begin errors++; $display("FAIL load ack step %0d: got %b want %b", i, bus.aou_pdu_clr_ack_tgl, m_ack); end
            if (bus.cnt_en !== m_cnt_en) begin errors++; $display("FAIL load cnt_en step %0d: got %b want %b", i, bus.cnt_en, m_cnt_en); end
            if (i >= 3 && bus.cnt_en !== (i == 13)) begin errors++; $display("FAIL load next_tick step %0d: got %b want %b", i, bus.cnt_en, (i == 13)); end
            if (i >= 3) begin
                vectors++;
                if (bus.pdu_aou_clr_reg !== 32'hDEADBEEF) begin errors++; $display("FAIL load clr_reg step %0d: got %h want deadbeef", i, bus.pdu_aou_clr_reg); end
            end
        end
    endtask

    task automatic test_prescale_lower();
        int n = 0;
        bus.pdu_aou_prescale = 16'd100;
        while (m_pre != 50 && n < 200) begin step(); n++; end
        vectors++;
        if (m_pre != 50) begin errors++; $display("FAIL lower reach_pre50: got %0d want 50", m_pre); end
        bus.pdu_aou_prescale = 16'd5;
        for (int i = 1; i <= 19; i++) begin
            step();
            vectors += 2;
            if (bus.cnt_en !== (i % 6 == 1)) begin errors++; $display("FAIL lower cnt_en step %0d: got %b want %b", i, bus.cnt_en, (i % 6 == 1)); end
            if (bus.cnt_en !== m_cnt_en) begin errors++; $display("FAIL lower_model cnt_en step %0d: got %b want %b", i, bus.cnt_en, m_cnt_en); end
        end
    endtask

    task automatic test_load_vs_tick();
        int          n = 0;
        logic [31:0] d;
        d = $urandom;
        bus.pdu_aou_prescale = 16'd5;
        while (m_pre != 3 && n < 20) begin step(); n++; end
        vectors++;
        if (m_pre != 3) begin errors++; $display("FAIL collide reach_pre3: got %0d want 3", m_pre); end
        do_toggle(d);
        for (int i = 1; i <= 10; i++) begin
            step();
            vectors += 3;
            if (bus.pdu_aou_wen_clr_sync !== (i == 3)) begin errors++; $display("FAIL collide strobe step %0d: got %b want %b", i, bus.pdu_aou_wen_clr_sync, (i == 3)); end
            if (bus.cnt_en !== (i == 9)) begin errors++; $display("FAIL collide cnt_en step %0d: got %b want %b", i, bus.cnt_en, (i == 9)); end
            if (bus.cnt_en !== m_cnt_en) begin errors++; $display("FAIL collide_model cnt_en step %0d: got %b want %b", i, bus.cnt_en, m_cnt_en); end
            if (i == 3) begin
                vectors++;
                if (bus.pdu_aou_clr_reg !== d) begin errors++; $display("FAIL collide clr_reg: got %h want %h", bus.pdu_aou_clr_reg, d); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(19, 0) == 0) bus.pdu_aou_en = ~bus.pdu_aou_en;
            if ($urandom_range(29, 0) == 0) bus.pdu_aou_prescale = PRE_W'($urandom_range(7, 0));
            if (due_q.size() == 0 && $urandom_range(7, 0) == 0) do_toggle($urandom);
            step();
            vectors += 5;
            if (bus.aou_pdu_en_sync !== m_en_sync) begin errors++; $display("FAIL rand en_sync edge %0d: got %b want %b", edge_no, bus.aou_pdu_en_sync, m_en_sync); end
            if (bus.cnt_en !== m_cnt_en) begin errors++; $display("FAIL rand cnt_en edge %0d: got %b want %b", edge_no, bus.cnt_en, m_cnt_en); end
            if (bus.pdu_aou_wen_clr_sync !== m_strobe) begin errors++; $display("FAIL rand strobe edge %0d: got %b want %b", edge_no, bus.pdu_aou_wen_clr_sync, m_strobe); end
            if (bus.aou_pdu_clr_ack_tgl !== m_ack) begin errors++; $display("FAIL rand ack edge %0d: got %b want %b", edge_no, bus.aou_pdu_clr_ack_tgl, m_ack); end
            if (bus.pdu_aou_clr_reg !== m_clr) begin errors++; $display("FAIL rand clr_reg edge %0d: got %h want %h", edge_no, bus.pdu_aou_clr_reg, m_clr); end
        end
        n_flush: for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_mid_reset();
        int n = 0;
        bus.pdu_aou_prescale = 16'd3;
        bus.pdu_aou_en = 1;
        while (!(m_run && m_pre == 1 && due_q.size() == 0) && n < 60) begin step(); n++; end
        do_toggle(32'h1234_5678);
        step();
        vectors++;
        if (!(m_run && m_pre == 2)) begin errors++; $display("FAIL midrst setup: got run=%0b pre=%0d want run=1 pre=2", m_run, m_pre); end
        #2;
        rtc_rst = 1;
        #1;
        vectors += 5;
        if (bus.aou_pdu_en_sync !== 1'b0) begin errors++; $display("FAIL midrst en_sync: got %b want 0", bus.aou_pdu_en_sync); end
        if (bus.cnt_en !== 1'b0) begin errors++; $display("FAIL midrst cnt_en: got %b want 0", bus.cnt_en); end
        if (bus.pdu_aou_wen_clr_sync !== 1'b0) begin errors++; $display("FAIL midrst strobe: got %b want 0", bus.pdu_aou_wen_clr_sync); end
        if (bus.aou_pdu_clr_ack_tgl !== 1'b0) begin errors++; $display("FAIL midrst ack: got %b want 0", bus.aou_pdu_clr_ack_tgl); end
        if (bus.pdu_aou_clr_reg !== 32'h0) begin errors++; $display("FAIL midrst clr_reg: got %h want 0", bus.pdu_aou_clr_reg); end
        bus.pdu_aou_wen_clr_tgl = 0;
        model_reset();
        @(posedge rtc_clk);
        #1;
        rtc_rst = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            vectors += 3;
            if (bus.cnt_en !== (i == 7 || i == 11)) begin errors++; $display("FAIL midrst_after cnt_en step %0d: got %b want %b", i, bus.cnt_en, (i == 7 || i == 11)); end
            if (bus.pdu_aou_wen_clr_sync !== 1'b0) begin errors++; $display("FAIL midrst_after strobe step %0d: got %b want 0", i, bus.pdu_aou_wen_clr_sync); end
            if (bus.aou_pdu_en_sync !== m_en_sync) begin errors++; $display("FAIL midrst_after en_sync step %0d: got %b want %b", i, bus.aou_pdu_en_sync, m_en_sync); end
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_prescale_zero();
        test_load();
        test_prescale_lower();
        test_load_vs_tick();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_no);
        $fatal(1, "timeout");
    end
endmodule
